digit_scan_mux: RTL and testbench

DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

---
 rtl/digit_scan_mux.sv | 120 ++++++++++++
 tb/tb_digit_scan_mux.sv | 137 +++++++++++++
 2 files changed

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed 7-segment display driver with BCD decode and optional blink
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      1 = scanning, 0 = display dark and scan frozen
//   digits      packed BCD, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp_mask     bit i lights the decimal point of digit i
//   blink_mask  bit i makes digit i blink (used only with DIGIT_SCAN_BLINK_EN)
//   anode_n     one-hot-low digit select, registered
//   seg_n       active-low segments {g,f,e,d,c,b,a}, registered
//   dp_n        active-low decimal point, registered
//   digit_idx   index of the digit currently driven, registered
//
// Macro DIGIT_SCAN_BLINK_EN builds the blink counter and phase; without it
// blink_mask is ignored.
module digit_scan_mux #(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [2:0]              digit_idx
);
    localparam int PW = $clog2(REFRESH_DIV);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_cfg_err
        $error("digit_scan_mux: NUM_DIGITS must be 2..8, REFRESH_DIV >= 2, BLINK_DIV >= 1");
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [PW-1:0]         presc_q, presc_d;
    logic [2:0]            idx_q, idx_d, didx_q, didx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  tick, blank;

    assign tick = enable && presc_q == PW'(REFRESH_DIV - 1);

`ifdef DIGIT_SCAN_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          bwrap;
    assign bwrap   = tick && bcnt_q == BW'(BLINK_DIV - 1);
    assign bcnt_d  = bwrap ? '0 : (tick ? bcnt_q + 1'b1 : bcnt_q);
    assign phase_d = bwrap ? ~phase_q : phase_q;
    // phase and index are both registered, so they refer to the same slot
    assign blank   = phase_q & blink_mask[idx_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blank        = 1'b0;
`endif

    always_comb begin
        presc_d = tick ? '0 : (enable ? presc_q + 1'b1 : presc_q);
        idx_d   = tick ? (idx_q == 3'(NUM_DIGITS - 1) ? 3'd0 : idx_q + 3'd1) : idx_q;
        anode_d = (enable && !blank) ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        seg_d   = enable ? seg7(digits[{idx_q, 2'b00} +: 4]) : 7'h7F;
        dp_d    = enable ? ~dp_mask[idx_q] : 1'b1;
        didx_d  = enable ? idx_q : didx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            didx_q  <= '0;
            anode_q <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            didx_q  <= didx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign anode_n   = anode_q;
    assign seg_n     = seg_q;
    assign dp_n      = dp_q;
    assign digit_idx = didx_q;
endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed self-checking bench for digit_scan_mux (6 digits, refresh 4, blink 2)
module tb_digit_scan_mux;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [23:0] digits;
    logic [5:0]  dp_mask;
    logic [5:0]  blink_mask;
    logic [5:0]  anode_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [2:0]  digit_idx;
    int          tests = 0;
    int          fails = 0;

    digit_scan_mux #(.NUM_DIGITS(6), .REFRESH_DIV(4), .BLINK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits),
        .dp_mask(dp_mask), .blink_mask(blink_mask), .anode_n(anode_n),
        .seg_n(seg_n), .dp_n(dp_n), .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic [5:0] an, input logic [2:0] idx);
        chk({tag, ".anode"}, 32'(anode_n), 32'(an));
        chk({tag, ".idx"}, 32'(digit_idx), 32'(idx));
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        digits     = 24'h543210;
        dp_mask    = 6'b000000;
        blink_mask = 6'b000000;
        cyc(2);
        chk_slot("rst", 6'b111111, 3'd0);
        chk("rst.seg", 32'(seg_n), 32'h7F);
        chk("rst.dp", 32'(dp_n), 32'd1);
        rst_n = 1'b1;
        cyc(1);
        chk_slot("s0a", 6'b111110, 3'd0);
        chk("s0a.seg", 32'(seg_n), 32'b1000000);
        chk("s0a.dp", 32'(dp_n), 32'd1);
        cyc(3);
        chk_slot("s0d", 6'b111110, 3'd0);
        cyc(1);
        chk_slot("s1", 6'b111101, 3'd1);
        chk("s1.seg", 32'(seg_n), 32'b1111001);
        cyc(4);
        chk_slot("s2", 6'b111011, 3'd2);
        chk("s2.seg", 32'(seg_n), 32'b0100100);
        cyc(4);
        chk("s3.seg", 32'(seg_n), 32'b0110000);
        cyc(4);
        chk("s4.seg", 32'(seg_n), 32'b0011001);
        cyc(4);
        chk_slot("s5", 6'b011111, 3'd5);
        chk("s5.seg", 32'(seg_n), 32'b0010010);
        cyc(4);
        chk_slot("wrap", 6'b111110, 3'd0);
        digits  = 24'h543A10;
        dp_mask = 6'b000100;
        cyc(4);
        chk_slot("f1s1", 6'b111101, 3'd1);
        chk("f1s1.dp", 32'(dp_n), 32'd1);
        cyc(4);
        chk_slot("blankA", 6'b111011, 3'd2);
        chk("blankA.seg", 32'(seg_n), 32'h7F);
        chk("blankA.dp", 32'(dp_n), 32'd0);
        digits  = 24'h543810;
        dp_mask = 6'b000000;
        cyc(1);
        chk("live.seg", 32'(seg_n), 32'b0000000);
        chk("live.dp", 32'(dp_n), 32'd1);
        chk_slot("live", 6'b111011, 3'd2);
        cyc(4);
        chk_slot("s3c2", 6'b110111, 3'd3);
        enable = 1'b0;
        cyc(1);
        chk_slot("dis1", 6'b111111, 3'd3);
        chk("dis1.seg", 32'(seg_n), 32'h7F);
        chk("dis1.dp", 32'(dp_n), 32'd1);
        cyc(9);
        chk_slot("dis10", 6'b111111, 3'd3);
        enable = 1'b1;
        cyc(1);
        chk_slot("re1", 6'b110111, 3'd3);
        cyc(1);
        chk_slot("re2", 6'b110111, 3'd3);
        cyc(1);
        chk_slot("re3", 6'b101111, 3'd4);
        cyc(1);
        #3 rst_n = 1'b0;
        #1;
        chk_slot("arst", 6'b111111, 3'd0);
        chk("arst.seg", 32'(seg_n), 32'h7F);
        chk("arst.dp", 32'(dp_n), 32'd1);
        blink_mask = 6'b000100;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk_slot("rel0", 6'b111110, 3'd0);
        cyc(3);
        chk_slot("rel3", 6'b111110, 3'd0);
        cyc(1);
        chk_slot("rel4", 6'b111101, 3'd1);
        cyc(4);
`ifdef DIGIT_SCAN_BLINK_EN
        chk_slot("blk0", 6'b111111, 3'd2);
        cyc(24);
        chk_slot("blk1", 6'b111011, 3'd2);
        cyc(24);
        chk_slot("blk2", 6'b111111, 3'd2);
`else
        chk_slot("blk0", 6'b111011, 3'd2);
        cyc(24);
        chk_slot("blk1", 6'b111011, 3'd2);
        cyc(24);
        chk_slot("blk2", 6'b111011, 3'd2);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
